flt_burst_engine: RTL and testbench



---
 rtl/flt_burst_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_flt_burst_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flt_burst_engine.sv
// Burst filter engine: AXI read -> per-pixel colour op -> FIFO -> AXI write.
// Define FLT_GRAY_EN to build the MODE 3 grayscale path (otherwise MODE 3 is pass).
module flt_burst_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN          = 16,
  parameter int FIFO_DEPTH         = 64
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            START,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   SRCADDR,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   DSTADDR,
  input  logic [23:0]                     NBEATS,
  input  logic [1:0]                      MODE,
  input  logic [31:0]                     COLOR,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int AXW   = C_M_AXI_ADDR_WIDTH;
  localparam int P     = C_M_AXI_DATA_WIDTH / 32;
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int CW    = FAW + 2;
  localparam int ALIGN = $clog2(BURST_LEN * C_M_AXI_DATA_WIDTH / 8);

  localparam logic [AXW-1:0] BURST_BYTES = AXW'(BURST_LEN * C_M_AXI_DATA_WIDTH / 8);
  localparam logic [AXW-1:0] ALIGN_MASK  = ~AXW'((64'd1 << ALIGN) - 64'd1);
  localparam logic [7:0]     LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [23:0]    BL24        = 24'(BURST_LEN);
  localparam logic [FAW:0]   BLC         = (FAW+1)'(BURST_LEN);

  localparam logic [1:0] RIDLE = 2'd0, RADDR = 2'd1, RDATA = 2'd2;
  localparam logic [1:0] WIDLE = 2'd0, WADDR = 2'd1, WDATA = 2'd2, WRESP = 2'd3;

  logic [1:0]                    r_rstate, r_wstate;
  logic                          r_busy, r_done, r_zero;
  logic [1:0]                    r_mode;
  logic [31:0]                   r_color;
  logic [23:0]                   r_rd_left, r_wr_left;
  logic [AXW-1:0]                r_araddr, r_awaddr;
  logic [7:0]                    r_arlen, r_awlen, r_beat;
  logic                          r_arvalid, r_awvalid, r_wvalid;
  logic                          r_pvalid;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_pdata;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FAW-1:0]                r_wptr, r_rptr;
  logic [FAW:0]                  r_count, r_inflight;

  logic                          w_start, w_space_ok, w_ar_fire, w_push, w_pop, w_last_b;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_proc;

  function automatic logic [31:0] f_pixel(input logic [31:0] px, input logic [1:0] mode,
                                          input logic [31:0] color);
`ifdef FLT_GRAY_EN
    logic [15:0] y;
`endif
    case (mode)
      2'd1: return px & color;
      2'd2: return px ^ color;
`ifdef FLT_GRAY_EN
      2'd3: begin
        y = 16'd77 * {8'h00, px[23:16]} + 16'd150 * {8'h00, px[15:8]} + 16'd29 * {8'h00, px[7:0]};
        return {px[31:24], y[15:8], y[15:8], y[15:8]};
      end
`endif
      default: return px;
    endcase
  endfunction

  always_comb begin
    w_proc = '0;
    for (int unsigned i = 0; i < P; i++)
      w_proc[i*32 +: 32] = f_pixel(M_AXI_RDATA[i*32 +: 32], r_mode, r_color);
  end

  assign w_start  = START && !r_busy;
  assign w_push   = r_pvalid;
  assign w_pop    = r_wvalid && M_AXI_WREADY;
  assign w_last_b = (r_wstate == WRESP) && M_AXI_BVALID && (r_wr_left == BL24);

  // Space is reserved per burst at AR time, so free minus reserved must cover a whole burst.
  assign w_space_ok = (CW'(r_count) + CW'(r_inflight) + CW'(BURST_LEN)) <= CW'(FIFO_DEPTH);
  assign w_ar_fire  = r_busy && (r_rd_left != '0) && w_space_ok &&
                      ((r_rstate == RIDLE) ||
                       ((r_rstate == RDATA) && M_AXI_RVALID && M_AXI_RLAST));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_mode  <= '0;
      r_color <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_busy  <= 1'b1;
        r_zero  <= (NBEATS == 24'd0);
        r_mode  <= MODE;
        r_color <= COLOR;
      end else if (r_busy && (r_zero || w_last_b)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_zero <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= RIDLE;
      r_rd_left <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arvalid <= 1'b0;
    end else begin
      if (w_start) begin
        r_rd_left <= NBEATS;
        r_araddr  <= SRCADDR & ALIGN_MASK;
        r_arlen   <= LAST_BEAT;
      end
      case (r_rstate)
        RIDLE: if (w_ar_fire) begin
          r_arvalid <= 1'b1;
          r_rd_left <= r_rd_left - BL24;
          r_rstate  <= RADDR;
        end
        RADDR: if (M_AXI_ARREADY) begin
          r_arvalid <= 1'b0;
          r_araddr  <= r_araddr + BURST_BYTES;
          r_rstate  <= RDATA;
        end
        RDATA: if (M_AXI_RVALID && M_AXI_RLAST) begin
          if (w_ar_fire) begin
            r_arvalid <= 1'b1;
            r_rd_left <= r_rd_left - BL24;
            r_rstate  <= RADDR;
          end else begin
            r_rstate <= RIDLE;
          end
        end
        default: r_rstate <= RIDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pvalid   <= 1'b0;
      r_pdata    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      r_pvalid <= (r_rstate == RDATA) && M_AXI_RVALID;
      if ((r_rstate == RDATA) && M_AXI_RVALID)
        r_pdata <= w_proc;
      if (w_push) r_wptr <= r_wptr + FAW'(1);
      if (w_pop)  r_rptr <= r_rptr + FAW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FAW+1)'(1);
        2'b01:   r_count <= r_count - (FAW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_inflight <= r_inflight + (w_ar_fire ? BLC : '0) - {{FAW{1'b0}}, w_push};
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wptr] <= r_pdata;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= WIDLE;
      r_wr_left <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_beat    <= '0;
    end else begin
      if (w_start) begin
        r_wr_left <= NBEATS;
        r_awaddr  <= DSTADDR & ALIGN_MASK;
        r_awlen   <= LAST_BEAT;
      end
      case (r_wstate)
        WIDLE: if (r_busy && (r_wr_left != '0) && (r_count >= BLC)) begin
          r_awvalid <= 1'b1;
          r_wstate  <= WADDR;
        end
        WADDR: if (M_AXI_AWREADY) begin
          r_awvalid <= 1'b0;
          r_awaddr  <= r_awaddr + BURST_BYTES;
          r_wvalid  <= 1'b1;
          r_beat    <= '0;
          r_wstate  <= WDATA;
        end
        WDATA: if (M_AXI_WREADY) begin
          r_beat <= r_beat + 8'd1;
          if (r_beat == LAST_BEAT) begin
            r_wvalid <= 1'b0;
            r_wstate <= WRESP;
          end
        end
        WRESP: if (M_AXI_BVALID) begin
          r_wr_left <= r_wr_left - BL24;
          if ((r_wr_left != BL24) && (r_count >= BLC)) begin
            r_awvalid <= 1'b1;
            r_wstate  <= WADDR;
          end else begin
            r_wstate <= WIDLE;
          end
        end
        default: r_wstate <= WIDLE;
      endcase
    end
  end

  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = (r_rstate == RDATA);
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wvalid ? r_mem[r_rptr] : '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = r_wvalid && (r_beat == LAST_BEAT);
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = (r_wstate == WRESP);

endmodule

// File: tb/tb_flt_burst_engine.sv
// Directed bench for flt_burst_engine with a cycle-level AXI slave/memory model.
// Grayscale expectations follow FLT_GRAY_EN.
module tb_flt_burst_engine;
  localparam int AW = 32, DW = 32, BL = 16, FD = 32;
  localparam int SRC_W = 32'h400, DST_W = 32'h1000, ALT_W = 32'h1800;

  logic          ACLK, ARESETN, START;
  logic [AW-1:0] SRCADDR, DSTADDR;
  logic [23:0]   NBEATS;
  logic [1:0]    MODE;
  logic [31:0]   COLOR;
  logic          BUSY, DONE;
  logic [AW-1:0] M_AXI_ARADDR, M_AXI_AWADDR;
  logic [7:0]    M_AXI_ARLEN, M_AXI_AWLEN;
  logic          M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [DW-1:0] M_AXI_RDATA, M_AXI_WDATA;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic          M_AXI_BVALID, M_AXI_BREADY;

  flt_burst_engine #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                     .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .SRCADDR(SRCADDR), .DSTADDR(DSTADDR),
    .NBEATS(NBEATS), .MODE(MODE), .COLOR(COLOR), .BUSY(BUSY), .DONE(DONE),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY));

  logic [31:0] mem [0:8191];
  int total = 0, bad = 0;
  int ar_cnt = 0, aw_cnt = 0, arlen_bad = 0, awlen_bad = 0, wlast_bad = 0, wstrb_bad = 0;
  int done_cnt = 0, valid_cnt = 0;
  int ar_delay = 0;
  bit bp_en = 0;

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  // Slave: inputs are set at the falling edge and the handshakes they form with the
  // (registered) DUT outputs are applied to the model immediately.
  initial begin : slave
    int ar_wait, r_left, w_beat;
    logic [12:0] r_idx, w_idx;
    bit b_pend;
    ar_wait = 0; r_left = 0; w_beat = 0; b_pend = 0; r_idx = '0; w_idx = '0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RDATA = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        ar_wait = 0; r_left = 0; w_beat = 0; b_pend = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RDATA = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
      end else begin
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= ar_delay);
        M_AXI_RVALID  = (r_left > 0);
        M_AXI_RDATA   = (r_left > 0) ? mem[r_idx] : '0;
        M_AXI_RLAST   = (r_left == 1);
        M_AXI_AWREADY = M_AXI_AWVALID;
        M_AXI_WREADY  = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
        M_AXI_BVALID  = b_pend;
        if (DONE) done_cnt++;
        if (M_AXI_ARVALID || M_AXI_AWVALID || M_AXI_WVALID) valid_cnt++;
        if (M_AXI_RVALID && M_AXI_RREADY) begin r_idx++; r_left--; end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_cnt++;
          if (M_AXI_ARLEN != 8'(BL - 1)) arlen_bad++;
          r_idx = M_AXI_ARADDR[14:2]; r_left = int'(M_AXI_ARLEN) + 1; ar_wait = 0;
        end else if (M_AXI_ARVALID) ar_wait++;
        if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 0;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_cnt++;
          if (M_AXI_AWLEN != 8'(BL - 1)) awlen_bad++;
          w_idx = M_AXI_AWADDR[14:2]; w_beat = 0;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          mem[w_idx] = M_AXI_WDATA; w_idx++; w_beat++;
          if (M_AXI_WLAST != (w_beat == BL)) wlast_bad++;
          if (M_AXI_WSTRB != 4'hF) wstrb_bad++;
          if (M_AXI_WLAST) b_pend = 1;
        end
      end
    end
  end

  function automatic logic [31:0] pat(input int i, input logic [31:0] seed);
    return seed + 32'(i) * 32'h01030507;
  endfunction

  task automatic fill(input int base, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) mem[base + i] = pat(i, seed);
  endtask

  task automatic clear(input int base, input int n);
    for (int i = 0; i < n; i++) mem[base + i] = 32'hDEADBEEF;
  endtask

  // Returns one cycle after the START cycle; inputs are then scrambled to prove latching.
  task automatic start_frame(input logic [31:0] src, input logic [31:0] dst, input logic [23:0] nb,
                             input logic [1:0] mode, input logic [31:0] color);
    @(negedge ACLK);
    SRCADDR = src; DSTADDR = dst; NBEATS = nb; MODE = mode; COLOR = color; START = 1;
    @(negedge ACLK);
    START = 0; SRCADDR = 32'h7000; DSTADDR = 32'h7800; NBEATS = nb + 24'd16;
    MODE = ~mode; COLOR = ~color;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge ACLK);
      if (DONE) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s_done: DONE not seen within %0d cycles", name, budget); end
    repeat (4) @(negedge ACLK);
  endtask

  task automatic test_reset;
    ARESETN = 0; START = 0; SRCADDR = '0; DSTADDR = '0; NBEATS = '0; MODE = '0; COLOR = '0;
    repeat (3) @(negedge ACLK);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", DONE); end
    total++; if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b000) begin
      bad++; $display("FAIL rst_valid: got %b want 000", {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID}); end
    total++; if ({M_AXI_RREADY, M_AXI_BREADY} !== 2'b00) begin
      bad++; $display("FAIL rst_ready: got %b want 00", {M_AXI_RREADY, M_AXI_BREADY}); end
    total++; if ({M_AXI_ARADDR, M_AXI_AWADDR} !== 64'h0) begin
      bad++; $display("FAIL rst_addr: got %h %h want 0", M_AXI_ARADDR, M_AXI_AWADDR); end
    total++; if ({M_AXI_ARLEN, M_AXI_AWLEN} !== 16'h0) begin
      bad++; $display("FAIL rst_len: got %h %h want 0", M_AXI_ARLEN, M_AXI_AWLEN); end
    total++; if (M_AXI_WDATA !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", M_AXI_WDATA); end
    ARESETN = 1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_pass;
    int a0 = ar_cnt, w0 = aw_cnt, d0 = done_cnt, al0 = arlen_bad, wl0 = awlen_bad, la0 = wlast_bad, s0 = wstrb_bad;
    fill(SRC_W, 64, 32'h11223344); clear(DST_W, 64);
    start_frame(32'h103F, 32'h4021, 24'd64, 2'd0, 32'h0);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL pass_busy: got %b want 1", BUSY); end
    total++; if (M_AXI_ARVALID !== 1'b0) begin bad++; $display("FAIL pass_ar_early: got %b want 0", M_AXI_ARVALID); end
    @(negedge ACLK);
    total++; if (M_AXI_ARVALID !== 1'b1) begin bad++; $display("FAIL pass_ar_lat: got %b want 1", M_AXI_ARVALID); end
    total++; if (M_AXI_ARADDR !== 32'h1000) begin bad++; $display("FAIL pass_araddr: got %h want 00001000", M_AXI_ARADDR); end
    wait_done("pass", 3000);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (mem[DST_W + i] !== pat(i, 32'h11223344)) begin
        bad++; $display("FAIL pass_data[%0d]: got %h want %h", i, mem[DST_W + i], pat(i, 32'h11223344)); end
    end
    total++; if (ar_cnt - a0 != 4) begin bad++; $display("FAIL pass_ar_count: got %0d want 4", ar_cnt - a0); end
    total++; if (aw_cnt - w0 != 4) begin bad++; $display("FAIL pass_aw_count: got %0d want 4", aw_cnt - w0); end
    total++; if (arlen_bad - al0 + awlen_bad - wl0 != 0) begin
      bad++; $display("FAIL pass_len: got %0d bad ARLEN/AWLEN want 0", arlen_bad - al0 + awlen_bad - wl0); end
    total++; if (wlast_bad - la0 != 0) begin bad++; $display("FAIL pass_wlast: got %0d bad want 0", wlast_bad - la0); end
    total++; if (wstrb_bad - s0 != 0) begin bad++; $display("FAIL pass_wstrb: got %0d bad want 0", wstrb_bad - s0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL pass_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_modes;
    logic [31:0] col [2] = '{32'h00FF00FF, 32'hFFFF0000};
    logic [31:0] exp [2] = '{32'h00340078, 32'hEDCB5678};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) mem[SRC_W + i] = 32'h12345678;
      clear(DST_W, 16);
      start_frame(32'h1000, 32'h4000, 24'd16, 2'(m + 1), col[m]);
      wait_done($sformatf("mode%0d", m + 1), 2000);
      for (int i = 0; i < 16; i += 5) begin
        total++;
        if (mem[DST_W + i] !== exp[m]) begin
          bad++; $display("FAIL mode%0d_data[%0d]: got %h want %h", m + 1, i, mem[DST_W + i], exp[m]); end
      end
    end
  endtask

  task automatic test_gray;
    logic [31:0] gin [3] = '{32'hAAFF0000, 32'h00FFFFFF, 32'h5A102030};
`ifdef FLT_GRAY_EN
    logic [31:0] gexp [3] = '{32'hAA4C4C4C, 32'h00FFFFFF, 32'h5A1D1D1D};
`else
    logic [31:0] gexp [3] = '{32'hAAFF0000, 32'h00FFFFFF, 32'h5A102030};
`endif
    for (int i = 0; i < 16; i++) mem[SRC_W + i] = gin[i % 3];
    clear(DST_W, 16);
    start_frame(32'h1000, 32'h4000, 24'd16, 2'd3, 32'h12345678);
    wait_done("gray", 2000);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (mem[DST_W + i] !== gexp[i % 3]) begin
        bad++; $display("FAIL gray_data[%0d]: got %h want %h", i, mem[DST_W + i], gexp[i % 3]); end
    end
  endtask

  task automatic test_backpressure;
    int d0 = done_cnt, la0 = wlast_bad, a0 = aw_cnt;
    int errs = 0;
    fill(SRC_W, 64, 32'h0BADF00D); clear(DST_W, 64);
    ar_delay = 5; bp_en = 1;
    start_frame(32'h1000, 32'h4000, 24'd64, 2'd0, 32'h0);
    wait_done("bp", 4000);
    ar_delay = 0; bp_en = 0;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (mem[DST_W + i] !== pat(i, 32'h0BADF00D)) begin
        bad++; errs++;
        if (errs < 8) $display("FAIL bp_data[%0d]: got %h want %h", i, mem[DST_W + i], pat(i, 32'h0BADF00D));
        else $display("FAIL bp_data[%0d]", i);
      end
    end
    total++; if (wlast_bad - la0 != 0) begin bad++; $display("FAIL bp_wlast: got %0d bad want 0", wlast_bad - la0); end
    total++; if (aw_cnt - a0 != 4) begin bad++; $display("FAIL bp_aw_count: got %0d want 4", aw_cnt - a0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_zero;
    int v0 = valid_cnt, d0 = done_cnt;
    start_frame(32'h1000, 32'h4000, 24'd0, 2'd0, 32'h0);
    total++; if ({BUSY, DONE} !== 2'b10) begin bad++; $display("FAIL zero_c1: got busy,done=%b want 10", {BUSY, DONE}); end
    @(negedge ACLK);
    total++; if ({BUSY, DONE} !== 2'b01) begin bad++; $display("FAIL zero_c2: got busy,done=%b want 01", {BUSY, DONE}); end
    @(negedge ACLK);
    total++; if ({BUSY, DONE} !== 2'b00) begin bad++; $display("FAIL zero_c3: got busy,done=%b want 00", {BUSY, DONE}); end
    repeat (5) @(negedge ACLK);
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL zero_valid: got %0d valid cycles want 0", valid_cnt - v0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_busy_ignore;
    int a0 = aw_cnt, d0 = done_cnt;
    fill(SRC_W, 32, 32'h600DCAFE); clear(DST_W, 32); clear(ALT_W, 16);
    start_frame(32'h1000, 32'h4000, 24'd32, 2'd0, 32'h0);
    repeat (3) @(negedge ACLK);
    start_frame(32'h1000, 32'h6000, 24'd16, 2'd2, 32'hFFFFFFFF);
    wait_done("ignore", 3000);
    total++; if (aw_cnt - a0 != 2) begin bad++; $display("FAIL ignore_aw_count: got %0d want 2", aw_cnt - a0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (mem[ALT_W] !== 32'hDEADBEEF) begin bad++; $display("FAIL ignore_alt: got %h want deadbeef", mem[ALT_W]); end
    for (int i = 0; i < 32; i += 7) begin
      total++;
      if (mem[DST_W + i] !== pat(i, 32'h600DCAFE)) begin
        bad++; $display("FAIL ignore_data[%0d]: got %h want %h", i, mem[DST_W + i], pat(i, 32'h600DCAFE)); end
    end
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    fill(SRC_W, 64, 32'h31415926); clear(DST_W, 64);
    start_frame(32'h1000, 32'h4000, 24'd64, 2'd0, 32'h0);
    repeat (6) @(negedge ACLK);
    total++; if ({BUSY, M_AXI_RREADY} !== 2'b11) begin
      bad++; $display("FAIL midrst_pre: got busy,rready=%b want 11", {BUSY, M_AXI_RREADY}); end
    #2 ARESETN = 0;
    #1;
    total++; if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, BUSY} !== 4'b0000) begin
      bad++; $display("FAIL midrst_drop: got arv,awv,wv,busy=%b want 0000",
                      {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, BUSY}); end
    total++; if ({M_AXI_RREADY, M_AXI_BREADY, DONE} !== 3'b000) begin
      bad++; $display("FAIL midrst_ready: got rr,br,done=%b want 000", {M_AXI_RREADY, M_AXI_BREADY, DONE}); end
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    fill(SRC_W, 64, 32'h27182818); clear(DST_W, 64);
    start_frame(32'h1000, 32'h4000, 24'd64, 2'd1, 32'hFFFFFFFF);
    wait_done("midrst", 3000);
    for (int i = 0; i < 64; i += 9) begin
      total++;
      if (mem[DST_W + i] !== pat(i, 32'h27182818)) begin
        bad++; $display("FAIL midrst_data[%0d]: got %h want %h", i, mem[DST_W + i], pat(i, 32'h27182818)); end
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL midrst_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_modes();
    test_gray();
    test_backpressure();
    test_zero();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
